// File: rtl/usb_rx_byte_pacer.sv
`default_nettype none
// ============================================================================
// usb_rx_byte_pacer : elastic byte FIFO that replays bytes as paced 1-cycle strobes
// Option macro: USB_RX_OVF_STICKY_EN (sticky overflow flag)     Rev 1.0
// ============================================================================
module usb_rx_byte_pacer #(
    parameter int DEPTH      = 64,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [LVL_W-1:0] c_full_level = LVL_W'(DEPTH);
    localparam logic [GAP_W-1:0] c_gap_load   = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    state_t           r_state;
    state_t           w_state_next;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_next;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;

    // Full/empty come from the registered count, so a same-cycle pop never frees a slot early.
    assign w_full   = (r_count == c_full_level);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_drop   = in_valid && w_full;
    assign in_ready = !w_full;
    assign fifo_level = r_count;

    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap_cnt;
        w_pop        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_STROBE;
                end
            end
            S_STROBE: begin
                w_gap_next   = c_gap_load;
                w_state_next = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_next = r_gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_gap_cnt <= w_gap_next;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            out_valid <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                out_data <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LVL_W'(1);
            end
        end
    end

`ifdef USB_RX_OVF_STICKY_EN
    // A drop wins over a simultaneous clear so no overflow event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= w_drop;
        end
    end
`endif

`ifndef SYNTHESIS
    a_single_cycle_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |=> !out_valid);
    a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= c_full_level);
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_byte_pacer.sv
`default_nettype none
// Bench for usb_rx_byte_pacer: three configurations share one stimulus stream,
// each checked against a queue-and-timestamp reference model.
module tb_usb_rx_byte_pacer;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       ovf_clr = 1'b0;

    logic       rdy  [N];
    logic       ov   [N];
    logic       ovf  [N];
    logic [7:0] od   [N];
    logic [2:0] lvl_a;
    logic [6:0] lvl_b;
    logic [3:0] lvl_c;

    int dep  [N] = '{4, 64, 8};
    int gapc [N] = '{1, 1, 3};

    usb_rx_byte_pacer #(.DEPTH(4), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]),
        .fifo_level(lvl_a), .overflow(ovf[0]), .ovf_clr(ovf_clr));

    usb_rx_byte_pacer #(.DEPTH(64), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]),
        .fifo_level(lvl_b), .overflow(ovf[1]), .ovf_clr(ovf_clr));

    usb_rx_byte_pacer #(.DEPTH(8), .GAP_CYCLES(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[2]), .out_data(od[2]), .out_valid(ov[2]),
        .fifo_level(lvl_c), .overflow(ovf[2]), .ovf_clr(ovf_clr));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model state
    logic [7:0] mq [N][$];
    int         next_ok [N];
    logic       m_valid [N];
    logic [7:0] m_data  [N];
    logic       m_ovf   [N];

    // observation state for the directed sequences
    logic [7:0] got [N][$];
    int         pt  [N][$];
    int         last_pulse [N];
    logic       prev_valid [N];
    int         maxlvl [N];
    int         ovf_seen [N];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ed;
        int         elvl;
    } vec_t;
    vec_t vec [13];

    function automatic int get_level(int k);
        case (k)
            0:       return int'(lvl_a);
            1:       return int'(lvl_b);
            default: return int'(lvl_c);
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            next_ok[k]    = cyc;
            m_valid[k]    = 1'b0;
            m_data[k]     = 8'h00;
            m_ovf[k]      = 1'b0;
            last_pulse[k] = -1;
            prev_valid[k] = 1'b0;
        end
    endtask

    task automatic clear_obs();
        for (int k = 0; k < N; k++) begin
            got[k].delete();
            pt[k].delete();
            maxlvl[k]   = 0;
            ovf_seen[k] = 0;
        end
    endtask

    // A byte may be emitted at edge e only if the previous emission was at least GAP+2 edges earlier.
    task automatic model_step(int k);
        bit full;
        bit pop;
        bit drop;
        full = (mq[k].size() == dep[k]);
        pop  = (mq[k].size() != 0) && (cyc >= next_ok[k]);
        m_valid[k] = pop;
        if (pop) begin
            m_data[k]  = mq[k].pop_front();
            next_ok[k] = cyc + gapc[k] + 2;
        end
        drop = in_valid && full;
        if (in_valid && !full) mq[k].push_back(in_data);
`ifdef USB_RX_OVF_STICKY_EN
        if (drop) m_ovf[k] = 1'b1;
        else if (ovf_clr) m_ovf[k] = 1'b0;
`else
        m_ovf[k] = drop;
`endif
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            check($sformatf("dut%0d out_valid", k), int'(ov[k]), int'(m_valid[k]));
            check($sformatf("dut%0d out_data", k), int'(od[k]), int'(m_data[k]));
            check($sformatf("dut%0d fifo_level", k), get_level(k), mq[k].size());
            check($sformatf("dut%0d in_ready", k), int'(rdy[k]), int'(mq[k].size() < dep[k]));
            check($sformatf("dut%0d overflow", k), int'(ovf[k]), int'(m_ovf[k]));
            if (ov[k]) begin
                check($sformatf("dut%0d strobe_back_to_back", k), int'(prev_valid[k]), 0);
                if (last_pulse[k] >= 0)
                    check($sformatf("dut%0d strobe_spacing_ok", k),
                          int'((cyc - last_pulse[k]) >= gapc[k] + 2), 1);
                last_pulse[k] = cyc;
                got[k].push_back(od[k]);
                pt[k].push_back(cyc);
            end
            prev_valid[k] = ov[k];
            if (get_level(k) > maxlvl[k]) maxlvl[k] = get_level(k);
            if (ovf[k]) ovf_seen[k]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < N; k++) model_step(k);
        end
        cyc++;
        #1;
        compare_all();
    endtask

    // Asserts reset between edges and verifies the outputs clear without a clock.
    task automatic async_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("dut%0d async_rst level", k), get_level(k), 0);
            check($sformatf("dut%0d async_rst out_valid", k), int'(ov[k]), 0);
            check($sformatf("dut%0d async_rst in_ready", k), int'(rdy[k]), 1);
        end
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int dens;
        logic rdy_low_seen;

        vec[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1};
        vec[1]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 0};
        vec[2]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 0};
        vec[3]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 0};
        vec[4]  = '{1'b1, 8'h3C, 1'b0, 8'hA5, 1};
        vec[5]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 0};
        vec[6]  = '{1'b1, 8'h77, 1'b0, 8'h3C, 1};
        vec[7]  = '{1'b1, 8'h88, 1'b0, 8'h3C, 2};
        vec[8]  = '{1'b0, 8'h00, 1'b1, 8'h77, 1};
        vec[9]  = '{1'b0, 8'h00, 1'b0, 8'h77, 1};
        vec[10] = '{1'b0, 8'h00, 1'b0, 8'h77, 1};
        vec[11] = '{1'b0, 8'h00, 1'b1, 8'h88, 0};
        vec[12] = '{1'b0, 8'h00, 1'b0, 8'h88, 0};

        model_reset();
        clear_obs();
        repeat (3) tick();
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < N; k++) begin
            check($sformatf("dut%0d reset out_valid", k), int'(ov[k]), 0);
            check($sformatf("dut%0d reset out_data", k), int'(od[k]), 0);
            check($sformatf("dut%0d reset in_ready", k), int'(rdy[k]), 1);
            check($sformatf("dut%0d reset level", k), get_level(k), 0);
            check($sformatf("dut%0d reset overflow", k), int'(ovf[k]), 0);
        end

        // single byte latency and short pairs, GAP_CYCLES=1 configurations
        for (int i = 0; i < 13; i++) begin
            in_valid = vec[i].v;
            in_data  = vec[i].d;
            tick();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("vec%0d dut%0d out_valid", i, k), int'(ov[k]), int'(vec[i].ev));
                check($sformatf("vec%0d dut%0d out_data", i, k), int'(od[k]), int'(vec[i].ed));
                check($sformatf("vec%0d dut%0d level", i, k), get_level(k), vec[i].elvl);
            end
        end
        in_valid = 1'b0;
        repeat (20) tick();

        // overflow: 8 back-to-back bytes into the DEPTH=4 instance drops 16 and 17
        clear_obs();
        rdy_low_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            tick();
            if (!rdy[0]) rdy_low_seen = 1'b1;
        end
        in_valid = 1'b0;
        repeat (40) tick();
        check("ovf in_ready_low_seen", int'(rdy_low_seen), 1);
        check("ovf dutA count", got[0].size(), 6);
        for (int i = 0; i < got[0].size() && i < 6; i++)
            check($sformatf("ovf dutA byte%0d", i), int'(got[0][i]), 16 + i);
        check("ovf dutB count", got[1].size(), 8);
`ifdef USB_RX_OVF_STICKY_EN
        check("ovf sticky held", int'(ovf[0]), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf sticky cleared", int'(ovf[0]), 0);
`else
        check("ovf pulse cycles", ovf_seen[0], 2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
`endif

        // back-to-back burst 01..0A
        clear_obs();
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (70) tick();
        for (int k = 1; k < N; k++) begin
            check($sformatf("burst dut%0d count", k), got[k].size(), 10);
            for (int i = 0; i < got[k].size() && i < 10; i++)
                check($sformatf("burst dut%0d byte%0d", k, i), int'(got[k][i]), i + 1);
            for (int i = 1; i < pt[k].size(); i++)
                check($sformatf("burst dut%0d interval%0d", k, i), pt[k][i] - pt[k][i-1], gapc[k] + 2);
        end

        // pointer wrap on DEPTH=4 with one byte every 4 cycles
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            in_valid = 1'b0;
            repeat (3) tick();
        end
        repeat (10) tick();
        check("wrap count", got[0].size(), 20);
        for (int i = 0; i < got[0].size() && i < 20; i++)
            check($sformatf("wrap byte%0d", i), int'(got[0][i]), i);
        check("wrap max level", maxlvl[0], 1);
        check("wrap no overflow", ovf_seen[0], 0);

        // reset in the middle of a burst
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC0 + 8'(i);
            tick();
        end
        async_reset();

        // randomized traffic with varying density, occasional clears and resets
        dens = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) dens = $urandom_range(10, 100);
            in_valid = ($urandom_range(0, 99) < dens);
            in_data  = 8'($urandom);
            ovf_clr  = ($urandom_range(0, 19) == 0);
            tick();
            if (i % 1000 == 600) async_reset();
        end
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        repeat (60) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
